// File: rtl/snn_step_scheduler.sv
// snn_step_scheduler: configures every neuron block, then runs TS steps of
// per-block updates followed by one spike exchange, with timeout and halt.
module snn_step_scheduler #(
  parameter int N       = 2,
  parameter int T       = 2,
  parameter int TS      = 5,
  parameter int TIMEOUT = 1024,
  parameter int TSW     = $clog2(TS + 1),
  parameter int BW      = (T > 1) ? $clog2(T) : 1
) (
  input  logic           aclk,
  input  logic           reset,
  input  logic           run,
  input  logic           halt,
  output logic [T-1:0]   cfg_req,
  input  logic [T-1:0]   cfg_ack,
  output logic [T-1:0]   blk_start,
  input  logic [T-1:0]   blk_done,
  output logic           xchg_start,
  input  logic           xchg_done,
  output logic [TSW-1:0] time_step,
  output logic [BW-1:0]  block_sel,
  output logic           busy,
  output logic           run_done,
  output logic           aborted,
  output logic           err_timeout
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, CFG, UPD, WAIT, XCHG, XWAIT, DONE} state_t;
  state_t         state, state_n;
  logic [CW-1:0]  tmo;
  logic [BW-1:0]  bsel_n;
  logic [TSW-1:0] ts_n;
  logic           err_n, abort, ack, last, expired;
  if (N < 1 || T < 1 || TS < 1 || TIMEOUT < 3) begin : g_bad_params
    $error("snn_step_scheduler: invalid parameters");
  end
  assign last    = block_sel == BW'(T - 1);
  // the wait is abandoned on the edge where the counter would reach TIMEOUT-1
  assign expired = tmo == CW'(TIMEOUT - 2);
  always_comb begin
    state_n = state;
    bsel_n  = block_sel;
    ts_n    = time_step;
    err_n   = err_timeout;
    abort   = 1'b0;
    ack     = 1'b0;
    case (state)
      IDLE: if (run) begin
        state_n = CFG;
        bsel_n  = '0;
        ts_n    = '0;
        err_n   = 1'b0;
      end
      CFG: begin
        ack = cfg_ack[block_sel];
        if (ack) begin
          state_n = last ? UPD : CFG;
          bsel_n  = last ? '0 : block_sel + 1'b1;
        end
      end
      UPD: state_n = WAIT;
      WAIT: begin
        ack = blk_done[block_sel];
        if (ack) begin
          state_n = last ? XCHG : UPD;
          bsel_n  = last ? block_sel : block_sel + 1'b1;
        end
      end
      XCHG: state_n = XWAIT;
      XWAIT: begin
        ack = xchg_done;
        if (ack) begin
          bsel_n  = '0;
          ts_n    = time_step + 1'b1;
          state_n = (ts_n == TSW'(TS)) ? DONE : UPD;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if ((state == CFG || state == WAIT || state == XWAIT) && !ack && expired) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
    // halt overrides any ack or timeout seen in the same cycle
    if (state != IDLE && halt) begin
      state_n = IDLE;
      bsel_n  = block_sel;
      ts_n    = time_step;
      err_n   = err_timeout;
      abort   = 1'b1;
    end
  end
  always_ff @(posedge aclk) begin
    if (reset) begin
      state       <= IDLE;
      tmo         <= '0;
      block_sel   <= '0;
      time_step   <= '0;
      err_timeout <= 1'b0;
      cfg_req     <= '0;
      blk_start   <= '0;
      xchg_start  <= 1'b0;
      busy        <= 1'b0;
      run_done    <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_n;
      tmo         <= (state_n != state || ack || state == IDLE) ? '0 : tmo + 1'b1;
      block_sel   <= bsel_n;
      time_step   <= ts_n;
      err_timeout <= err_n;
      cfg_req     <= (state_n == CFG) ? T'(1) << bsel_n : '0;
      blk_start   <= (state_n == UPD) ? T'(1) << bsel_n : '0;
      xchg_start  <= state_n == XCHG;
      busy        <= state_n != IDLE;
      run_done    <= state_n == DONE;
      aborted     <= abort;
    end
  end
  assert property (@(posedge aclk) disable iff (reset) $onehot0(cfg_req) && $onehot0(blk_start));
endmodule

// File: doc/snn_step_scheduler.md
Name: snn_step_scheduler

Overview:
Top-level sequencer for the SNN core. It configures each of the T neuron blocks, then runs TS time steps. In each step it starts every block's neuron update in turn, then runs one spike-exchange phase between blocks. It sits between the AXI4 control/status registers and the per-block neuron datapaths, and it owns the global time-step counter.

Parameters:
N, 2, neurons per block (informational; sizes nothing here, passed through for assertions)
T, 2, number of neuron blocks
TS, 5, number of time steps per run (ALPHA = 4 + 1)
TIMEOUT, 1024, maximum cycles to wait for any single ack/done before aborting with error
TSW, $clog2(TS+1), width of time_step
BW, max(1,$clog2(T)), width of block_sel

Ports:
aclk  in  1  clock
reset  in  1  synchronous active-high reset
run  in  1  1-cycle start request
halt  in  1  abort current run
cfg_req  out  T  one-hot, held until the matching cfg_ack
cfg_ack  in  T  block config loaded (V_0, V_REST, V_LEAK, K_SYN, RP)
blk_start  out  T  one-hot 1-cycle pulse: start the neuron update for one step
blk_done  in  T  block finished the update for this step
xchg_start  out  1  1-cycle pulse: start the spike exchange
xchg_done  in  1  spike exchange finished
time_step  out  TSW  current step index
block_sel  out  BW  block currently addressed
busy  out  1  high in every non-IDLE state
run_done  out  1  1-cycle pulse when a run completes normally
aborted  out  1  1-cycle pulse when halt terminates a run
err_timeout  out  1  sticky until the next accepted run

Behaviour:
- One clock, aclk. Reset is synchronous and active-high. On reset: state = IDLE and every output = 0. This includes err_timeout, time_step and block_sel.
- FSM states: IDLE, CFG, UPD, WAIT, XCHG, XWAIT, DONE.
- IDLE:
  - run = 1 clears time_step, block_sel and err_timeout, then goes to CFG.
  - run while not IDLE is ignored.
- CFG:
  - cfg_req[block_sel] = 1, and it stays high until cfg_ack[block_sel] is sampled high.
  - cfg_ack bits for other blocks are ignored.
  - On ack: if block_sel == T-1, set block_sel = 0 and go to UPD; else increment block_sel.
- UPD: lasts exactly one cycle. blk_start[block_sel] = 1, then go to WAIT.
- WAIT:
  - blk_done is sampled only in WAIT. A done that arrives in the UPD cycle is lost, so responders must assert done no earlier than the cycle after blk_start.
  - On blk_done[block_sel]: if block_sel == T-1, go to XCHG; else increment block_sel and go to UPD.
- XCHG: lasts one cycle. xchg_start = 1, then go to XWAIT.
- XWAIT:
  - On xchg_done, set block_sel = 0 and increment time_step.
  - If the new value == TS, go to DONE; else go to UPD.
- DONE: run_done = 1 for one cycle, then go to IDLE. time_step holds TS and block_sel holds 0 until the next run.
- Sequencing: blocks are always serviced in order 0..T-1, and a step never starts before the previous step's exchange completes.
- Timeout:
  - A counter clears on every state entry and increments each cycle in CFG, WAIT and XWAIT.
  - When it reaches TIMEOUT-1 without the awaited ack, err_timeout goes to 1 and the FSM goes to IDLE.
  - time_step and block_sel freeze at the failing point. run_done is not pulsed.
- Halt:
  - halt in any non-IDLE state forces IDLE on the next edge. aborted = 1 for one cycle; cfg_req, blk_start and xchg_start go to 0.
  - Halt takes priority over ack, done and timeout in the same cycle.
  - halt in IDLE does nothing.
- Simultaneous run and halt in IDLE: run wins, and halt is ignored.
- Reset mid-run: returns to IDLE with all outputs 0. No run_done or aborted pulse.
- Outputs are registered. cfg_req drops in the cycle after the ack is sampled.

Test Plan:
- Defaults, responders ack/done one cycle after request, pulse run → blk_start pattern 01,10 each followed by one xchg_start, repeated 5 times (10 blk_start, 5 xchg_start). time_step steps 0..5. Exactly one run_done. busy high from the cycle after run until the cycle after run_done.
- Block 1 delays blk_done by 20 cycles in step 2 → xchg_start for step 2 occurs at least 20 cycles after blk_start[1]. No blk_start[0] for step 3 until xchg_done. Totals are unchanged.
- cfg_ack[1] asserted while cfg_req = 01 → ignored, FSM stays on block 0. cfg_ack[0] then advances to cfg_req = 10.
- TIMEOUT=16, block 0 never acks in WAIT at step 3 → err_timeout = 1 after 15 WAIT cycles, time_step = 3, block_sel = 0, state IDLE, no run_done. A new run clears err_timeout.
- halt during XWAIT of step 1 → aborted pulse next cycle, busy = 0, all requests 0. A new run restarts at time_step 0 with CFG.
- run pulsed during WAIT → no effect. Reset asserted mid-run → all outputs 0 next cycle, no pulses.
